// File: rtl/led_blink_multi.sv
// led_blink_multi: independent LED channels, each OFF / ON / BLINK / BURST with its own half-period.
module led_blink_multi #(
    parameter int NUM_CH = 4,
    parameter int CNT_W = 13,
    parameter int DEFAULT_PERIOD = 5200,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [3:0]        cfg_pulses,
    output logic [NUM_CH-1:0] led
);
    typedef enum logic [1:0] {PULSE_ON, PULSE_OFF, GAP} bst_e;
    localparam logic [1:0] M_ON = 2'd1, M_BLINK = 2'd2, M_BURST = 2'd3;
    logic ready_q;
    logic acc;
    assign acc = cfg_valid && ready_q;
    assign cfg_ready = ready_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) ready_q <= 1'b0;
        else ready_q <= !acc;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0] mode_q, mode_d, gap_q, gap_d;
        logic [CNT_W-1:0] per_q, per_d, cnt_q, cnt_d;
        logic [3:0] n_q, n_d, rem_q, rem_d;
        bst_e st_q, st_d;
        logic led_q, led_d;
        logic wr, run, pend;
        assign wr = acc && (cfg_ch == CH_W'(i));
        // BURST with zero pulses is parked: no counting, no phase ends
        assign run = (mode_q == M_BLINK) || (mode_q == M_BURST && n_q != 4'd0);
        assign pend = run && (cnt_q == per_q);
        assign led[i] = led_q;
        always_comb begin
            mode_d = mode_q;
            per_d = per_q;
            n_d = n_q;
            cnt_d = cnt_q;
            rem_d = rem_q;
            gap_d = gap_q;
            st_d = st_q;
            led_d = led_q;
            if (wr) begin
                mode_d = cfg_mode;
                per_d = cfg_period;
                n_d = cfg_pulses;
                cnt_d = '0;
                rem_d = cfg_pulses - 4'd1;
                gap_d = 2'd0;
                st_d = (cfg_mode == M_BURST && cfg_pulses == 4'd0) ? GAP : PULSE_ON;
                led_d = cfg_mode == M_ON || cfg_mode == M_BLINK || (cfg_mode == M_BURST && cfg_pulses != 4'd0);
            end else if (!run) begin
                cnt_d = '0;
            end else if (!pend) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = '0;
                if (mode_q == M_BLINK) begin
                    led_d = !led_q;
                end else if (st_q == PULSE_ON) begin
                    st_d = PULSE_OFF;
                    led_d = 1'b0;
                end else if (st_q == PULSE_OFF) begin
                    st_d = (rem_q != 4'd0) ? PULSE_ON : GAP;
                    led_d = rem_q != 4'd0;
                    rem_d = (rem_q != 4'd0) ? rem_q - 4'd1 : rem_q;
                    gap_d = 2'd0;
                end else begin
                    // gap spans four phases; the 2-bit count wraps back to 0 on exit
                    gap_d = gap_q + 2'd1;
                    st_d = (gap_q == 2'd3) ? PULSE_ON : GAP;
                    led_d = gap_q == 2'd3;
                    rem_d = (gap_q == 2'd3) ? n_q - 4'd1 : rem_q;
                end
            end
        end
        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) begin
                mode_q <= M_BLINK;
                per_q <= CNT_W'(DEFAULT_PERIOD);
                n_q <= 4'd1;
                cnt_q <= '0;
                rem_q <= 4'd0;
                gap_q <= 2'd0;
                st_q <= PULSE_ON;
                led_q <= 1'b1;
            end else begin
                mode_q <= mode_d;
                per_q <= per_d;
                n_q <= n_d;
                cnt_q <= cnt_d;
                rem_q <= rem_d;
                gap_q <= gap_d;
                st_q <= st_d;
                led_q <= led_d;
            end
    end
endmodule

// File: tb/tb_led_blink_multi.sv
// tb_led_blink_multi: directed and random writes checked each cycle against an arithmetic pattern model.
module tb_led_blink_multi;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic cfg_valid = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [1:0] cfg_mode = '0;
    logic [7:0] cfg_period = '0;
    logic [3:0] cfg_pulses = '0;
    logic cfg_ready, cfg_ready3;
    logic [3:0] led;
    logic [2:0] led3;
    int checks = 0;
    int errors = 0;
    logic [1:0] m_mode [4];
    int m_p [4];
    int m_n [4];
    int m_t [4];
    logic m_ready;

    always #5 clk = ~clk;

    led_blink_multi #(.NUM_CH(4), .CNT_W(8), .DEFAULT_PERIOD(3)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
        .cfg_pulses(cfg_pulses), .led(led)
    );
    // three-channel build sees the same traffic; writes to index 3 must be discarded there
    led_blink_multi #(.NUM_CH(3), .CNT_W(8), .DEFAULT_PERIOD(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready3),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
        .cfg_pulses(cfg_pulses), .led(led3)
    );

    // LED level t cycles after a channel's start edge, from phase index arithmetic
    function automatic logic ref_led(input logic [1:0] m, input int p, input int n, input int t);
        int ph, q;
        ph = t / (p + 1);
        if (m == 2'd0) return 1'b0;
        if (m == 2'd1) return 1'b1;
        if (m == 2'd2) return (ph % 2) == 0;
        if (n == 0) return 1'b0;
        q = ph % (2 * n + 4);
        return (q < 2 * n) && (q % 2 == 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_mode[i] = 2'd2;
            m_p[i] = 3;
            m_n[i] = 1;
            m_t[i] = 0;
        end
        m_ready = 1'b0;
    endtask

    task automatic model_edge();
        logic acc;
        if (!reset_n) begin
            model_reset();
            return;
        end
        acc = cfg_valid && m_ready;
        for (int i = 0; i < 4; i++)
            if (acc && int'(cfg_ch) == i) begin
                m_mode[i] = cfg_mode;
                m_p[i] = int'(cfg_period);
                m_n[i] = int'(cfg_pulses);
                m_t[i] = 0;
            end else begin
                m_t[i]++;
            end
        m_ready = !acc;
    endtask

    task automatic chk();
        logic [3:0] e;
        for (int i = 0; i < 4; i++) e[i] = ref_led(m_mode[i], m_p[i], m_n[i], m_t[i]);
        checks++;
        assert (led === e) else begin
            errors++;
            $error("FAIL led4: observed %b expected %b", led, e);
        end
        checks++;
        assert (led3 === e[2:0]) else begin
            errors++;
            $error("FAIL led3: observed %b expected %b", led3, e[2:0]);
        end
        checks++;
        assert (cfg_ready === m_ready && cfg_ready3 === m_ready) else begin
            errors++;
            $error("FAIL ready: observed %b/%b expected %b", cfg_ready, cfg_ready3, m_ready);
        end
    endtask

    task automatic cyc(input int k = 1);
        for (int j = 0; j < k; j++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            chk();
        end
    endtask

    task automatic wr(input logic [1:0] ch, input logic [1:0] m, input logic [7:0] p, input logic [3:0] n);
        if (!m_ready) cyc();
        cfg_valid = 1'b1;
        cfg_ch = ch;
        cfg_mode = m;
        cfg_period = p;
        cfg_pulses = n;
        cyc();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int n;
        #2 reset_n = 1'b0;
        model_reset();
        #1 chk();
        cyc(3);
        reset_n = 1'b1;
        cyc(16);
        wr(2'd1, 2'd2, 8'd0, 4'd0);
        cyc(10);
        wr(2'd2, 2'd3, 8'd1, 4'd3);
        cyc(30);
        wr(2'd3, 2'd3, 8'd2, 4'd0);
        cyc();
        cfg_valid = 1'b1;
        cfg_ch = 2'd0;
        cfg_mode = 2'd0;
        cyc(2);
        cfg_mode = 2'd1;
        cyc(2);
        cfg_valid = 1'b0;
        cyc(3);
        wr(2'd3, 2'd1, 8'd1, 4'd1);
        cyc(4);
        wr(2'd0, 2'd2, 8'd2, 4'd0);
        n = 0;
        while (!(m_ready && (m_t[0] % 3) == 2 && ref_led(m_mode[0], m_p[0], m_n[0], m_t[0])) && n < 50) begin
            cyc();
            n++;
        end
        checks++;
        assert (n < 50) else begin
            errors++;
            $error("FAIL phase_end_wait: observed %0d cycles expected <50", n);
        end
        wr(2'd0, 2'd2, 8'd4, 4'd0);
        cyc(12);
        for (int k = 0; k < 600; k++) begin
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_ch = 2'($urandom_range(0, 3));
            cfg_mode = 2'($urandom_range(0, 3));
            cfg_period = 8'($urandom_range(0, 5));
            cfg_pulses = 4'($urandom_range(0, 4));
            cyc();
        end
        cfg_valid = 1'b0;
        wr(2'd2, 2'd3, 8'd2, 4'd2);
        cyc(7);
        reset_n = 1'b0;
        #1 model_reset();
        chk();
        cyc(2);
        reset_n = 1'b1;
        cyc(12);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_blink_multi.md
LED_BLINK_MULTI -- requirements
Module: led_blink_multi

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning number of independent LED channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 13, meaning width of each channel's period counter.
REQ-003 The block SHALL have parameter DEFAULT_PERIOD, default 5200, meaning the half-period terminal count loaded at reset.
REQ-004 The block SHALL have derived localparam CH_W = max(1, clog2(NUM_CH)).
REQ-005 Port clk, input, 1: single clock for all logic.
REQ-006 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port cfg_valid, input, 1: configuration write request.
REQ-008 Port cfg_ready, output, 1: block can accept a configuration write.
REQ-009 Port cfg_ch, input, CH_W: target channel index.
REQ-010 Port cfg_mode, input, 2: 0 OFF, 1 ON, 2 BLINK, 3 BURST.
REQ-011 Port cfg_period, input, CNT_W: half-period terminal count P.
REQ-012 Port cfg_pulses, input, 4: pulses per burst N (BURST mode only).
REQ-013 Port led, output, NUM_CH: registered LED drive, bit i = channel i.

Function
REQ-014 A write SHALL be accepted on a rising clk edge where cfg_valid and cfg_ready are both 1.
REQ-015 cfg_ready SHALL be 0 in the cycle immediately after an accept and 1 otherwise (out of reset); back-to-back writes therefore take 2 cycles each.
REQ-016 On accept with cfg_ch < NUM_CH, the channel SHALL latch mode/P/N, clear its counter to 0, and drive its led bit to the mode's start value on the same edge.
REQ-017 An accepted write with cfg_ch >= NUM_CH SHALL be discarded with no state change; cfg_ready still drops for one cycle.
REQ-018 Each phase SHALL last exactly P+1 clk cycles: counter increments 0..P; at count==P the phase ends and the counter returns to 0; P=0 gives 1-cycle phases.
REQ-019 OFF: led bit 0 constantly; counter held at 0.
REQ-020 ON: led bit 1 constantly; counter held at 0.
REQ-021 BLINK: led starts at 1 and toggles at every phase end (square wave, period 2(P+1)).
REQ-022 BURST: per-channel FSM states PULSE_ON, PULSE_OFF, GAP; start state PULSE_ON with led=1 and remaining-pulse count N-1.
REQ-023 BURST transitions at phase end: PULSE_ON -> PULSE_OFF (led 0); PULSE_OFF -> PULSE_ON (led 1, remaining-1) if remaining > 0, else -> GAP (led 0); GAP lasts 4 phases, then -> PULSE_ON with remaining reloaded to N-1.
REQ-024 BURST with N=0 SHALL behave as OFF (led 0, FSM held in GAP, counter held at 0).
REQ-025 Channels SHALL be fully independent; a write to one channel SHALL NOT disturb another channel's counter, state or led.
REQ-026 A write arriving on the same edge as the target channel's phase end SHALL take priority: the new configuration and start value apply, and the phase-end action is dropped.
REQ-027 Counter SHALL never exceed P; if a write lowers P, counting restarts from 0 anyway (REQ-016), so no wrap through 2^CNT_W occurs.

Reset
REQ-028 While reset_n is 0, every channel SHALL be BLINK, P=DEFAULT_PERIOD, N=1, counter 0, FSM PULSE_ON, led all 1s, cfg_ready 0, asynchronously.
REQ-029 cfg_ready SHALL rise on the first rising clk edge after reset_n deasserts; blinking resumes from counter 0.
REQ-030 Reset asserted mid-phase or mid-burst SHALL abandon all progress and return to REQ-028 values.

Verification (NUM_CH=4, CNT_W=8, DEFAULT_PERIOD=3)
REQ-031 Reset release, no writes -> all led bits 1 for 4 cycles, 0 for 4, repeating; cfg_ready 1 from first edge.
REQ-032 Write ch1 BLINK P=0 -> led[1] toggles every cycle starting 1 after accept edge; other bits unaffected; cfg_ready low exactly 1 cycle.
REQ-033 Write ch2 BURST P=1 N=3 -> led[2] pattern 11 00 11 00 11 00 00000000 (8-cycle gap) then repeats.
REQ-034 Write ch3 BURST N=0, then ch0 OFF, then ch0 ON with cfg_valid held high -> led[3]=0, led[0]=0 then 1, accepts spaced 2 cycles apart.
REQ-035 Write cfg_ch=5 (CH_W=2 wraps; use NUM_CH=3 build, cfg_ch=3) -> no led change, cfg_ready drops 1 cycle.
REQ-036 Write to ch0 coinciding with its phase end, and reset_n pulsed low mid-burst -> write value wins; after reset all channels match REQ-028.
